// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Scoreboard-based stall/bubble/flush controller for the in-order
//            pipeline, with a saturating stall counter. The compile-time macro
//            PIPE_HAZARD_FWD_EN enables forwarding select and load-use-only stalls.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES     = 3,
    parameter int REG_AW         = 5,
    parameter int LOAD_RDY_STAGE = 1,
    parameter int FLUSH_CYCLES   = 1,
    parameter int CNT_W          = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              id_valid_i,
    input  logic [REG_AW-1:0]                 id_rs1_i,
    input  logic [REG_AW-1:0]                 id_rs2_i,
    input  logic                              id_use_rs1_i,
    input  logic                              id_use_rs2_i,
    input  logic [REG_AW-1:0]                 id_rd_i,
    input  logic                              id_rf_w_en_i,
    input  logic                              id_is_load_i,
    input  logic                              br_taken_i,
    input  logic                              ext_stall_i,
    output logic                              stall_o,
    output logic                              bubble_o,
    output logic                              flush_o,
    output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_a_o,
    output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_b_o,
    output logic [CNT_W-1:0]                  stall_cnt_o
);

    localparam int FWD_W = $clog2(NUM_STAGES + 1);
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
`ifdef PIPE_HAZARD_FWD_EN
    localparam bit C_FWD_EN = 1'b1;
`else
    localparam bit C_FWD_EN = 1'b0;
`endif

    logic [NUM_STAGES-1:0]             r_vld;
    logic [NUM_STAGES-1:0]             r_ld;
    logic [NUM_STAGES-1:0][REG_AW-1:0] r_rd;
    logic [FC_W-1:0]                   r_fcnt;
    logic [CNT_W-1:0]                  r_cnt;

    logic             w_hit_a, w_hit_b;
    logic             w_blk_a, w_blk_b;
    logic [FWD_W-1:0] w_sel_a, w_sel_b;
    logic             w_hazard, w_kill, w_hz, w_accept;

    // Scan oldest to youngest so the youngest match is the one left standing.
    // A match blocks ID always without forwarding, or only for a load still
    // short of its forwardable stage with forwarding.
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        w_blk_a = 1'b0;
        w_blk_b = 1'b0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (id_use_rs1_i && (id_rs1_i != '0) && r_vld[k] && (r_rd[k] == id_rs1_i)) begin
                w_hit_a = 1'b1;
                w_sel_a = FWD_W'(k + 1);
                w_blk_a = !C_FWD_EN || (r_ld[k] && (k < LOAD_RDY_STAGE));
            end
            if (id_use_rs2_i && (id_rs2_i != '0) && r_vld[k] && (r_rd[k] == id_rs2_i)) begin
                w_hit_b = 1'b1;
                w_sel_b = FWD_W'(k + 1);
                w_blk_b = !C_FWD_EN || (r_ld[k] && (k < LOAD_RDY_STAGE));
            end
        end
    end

    assign w_hazard = w_blk_a | w_blk_b;
    assign w_kill   = (r_fcnt != '0);
    assign w_hz     = id_valid_i & ~w_kill & w_hazard;
    assign w_accept = br_taken_i & id_valid_i & ~w_hz & ~w_kill & ~ext_stall_i;

    assign stall_o     = w_hz;
    assign bubble_o    = w_hz | w_kill;
    assign flush_o     = w_kill;
    assign stall_cnt_o = r_cnt;
    assign fwd_a_o     = (C_FWD_EN && w_hit_a && !w_hazard) ? w_sel_a : '0;
    assign fwd_b_o     = (C_FWD_EN && w_hit_b && !w_hazard) ? w_sel_b : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld  <= '0;
            r_ld   <= '0;
            r_rd   <= '0;
            r_fcnt <= '0;
            r_cnt  <= '0;
        end else if (!ext_stall_i) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_rd[k]  <= r_rd[k-1];
            end
            r_vld[0] <= id_valid_i & ~bubble_o & id_rf_w_en_i & (id_rd_i != '0);
            r_ld[0]  <= id_is_load_i;
            r_rd[0]  <= id_rd_i;
            if (w_accept) begin
                r_fcnt <= FC_W'(FLUSH_CYCLES);
            end else if (w_kill) begin
                r_fcnt <= r_fcnt - 1'b1;
            end
            if (w_hz && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed-vector scoreboard bench for pipe_hazard_ctrl; follows
//            PIPE_HAZARD_FWD_EN to select the expected stall/forward pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int SLEN    = FWD ? 1 : 3;  // stall length of a directly dependent user

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid_i, id_use_rs1_i, id_use_rs2_i, id_rf_w_en_i, id_is_load_i;
    logic [4:0]       id_rs1_i, id_rs2_i, id_rd_i;
    logic             br_taken_i, ext_stall_i;
    logic             stall_o, bubble_o, flush_o;
    logic [1:0]       fwd_a_o, fwd_b_o;
    logic [CNT_W-1:0] stall_cnt_o;

    pipe_hazard_ctrl #(
        .NUM_STAGES     (3),
        .REG_AW         (5),
        .LOAD_RDY_STAGE (1),
        .FLUSH_CYCLES   (2),
        .CNT_W          (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid_i   (id_valid_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .id_rd_i      (id_rd_i),
        .id_rf_w_en_i (id_rf_w_en_i),
        .id_is_load_i (id_is_load_i),
        .br_taken_i   (br_taken_i),
        .ext_stall_i  (ext_stall_i),
        .stall_o      (stall_o),
        .bubble_o     (bubble_o),
        .flush_o      (flush_o),
        .fwd_a_o      (fwd_a_o),
        .fwd_b_o      (fwd_b_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        logic  st, bb, fl;
        int    fa, fb, cnt;   // fa/fb < 0: not checked
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   ecnt  = 0;

    task automatic cyc(input string nm, input logic rn, input logic v,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld,
                       input logic br, input logic es,
                       input logic est, input logic ebb, input logic efl,
                       input int efa, input int efb);
        exp_t x;
        @(posedge clk);
        #1;
        reset        = rn;
        id_valid_i   = v;
        id_rs1_i     = rs1;
        id_use_rs1_i = u1;
        id_rs2_i     = rs2;
        id_use_rs2_i = u2;
        id_rd_i      = rd;
        id_rf_w_en_i = we;
        id_is_load_i = ld;
        br_taken_i   = br;
        ext_stall_i  = es;
        if (!rn) ecnt = 0;
        x.nm = nm; x.st = est; x.bb = ebb; x.fl = efl;
        x.fa = efa; x.fb = efb; x.cnt = ecnt;
        q.push_back(x);
        if (rn && est && !es && ecnt < CNT_MAX) ecnt++;
    endtask

    task automatic op(input string nm, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic est, input int efa, input int efb);
        cyc(nm, 1, 1, rs1, u1, rs2, u2, rd, we, ld, 0, 0, est, est, 0, efa, efb);
    endtask

    task automatic idle(input string nm, input int n);
        for (int i = 0; i < n; i++)
            cyc(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (stall_o !== e.st || bubble_o !== e.bb || flush_o !== e.fl ||
                (e.fa >= 0 && fwd_a_o !== e.fa[1:0]) ||
                (e.fb >= 0 && fwd_b_o !== e.fb[1:0]) ||
                stall_cnt_o !== e.cnt[CNT_W-1:0]) begin
                n_bad++;
                $display("FAIL %s: got stall=%b bubble=%b flush=%b fwd_a=%0d fwd_b=%0d cnt=%0d, expected stall=%b bubble=%b flush=%b fwd_a=%0d fwd_b=%0d cnt=%0d",
                         e.nm, stall_o, bubble_o, flush_o, fwd_a_o, fwd_b_o, stall_cnt_o,
                         e.st, e.bb, e.fl, e.fa, e.fb, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d vectors checked", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_use_rs1_i = 0; id_use_rs2_i = 0;
        id_rd_i = 0; id_rf_w_en_i = 0; id_is_load_i = 0; br_taken_i = 0; ext_stall_i = 0;

        cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("idle_after_reset", 2);

`ifdef PIPE_HAZARD_FWD_EN
        op("add_x5",   0, 0, 0, 0, 5,  1, 0, 0, 0, 0);
        op("sub_fwd1", 5, 1, 0, 0, 10, 1, 0, 0, 1, 0);
        op("add_x5b",  0, 0, 0, 0, 5,  1, 0, 0, 0, 0);
        op("indep",    0, 0, 0, 0, 9,  1, 0, 0, 0, 0);
        op("sub_fwd2", 5, 1, 0, 0, 10, 1, 0, 0, 2, 0);
        idle("drain", 3);
        op("lw_x6",    0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
        op("lu_stall", 0, 0, 6, 1, 0, 0, 0, 1, -1, -1);
        op("lu_fwd2",  0, 0, 6, 1, 0, 0, 0, 0, 0, 2);
        idle("drain", 3);
`else
        op("add_x7", 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        repeat (3) op("raw_stall", 7, 1, 0, 0, 8, 1, 0, 1, 0, 0);
        op("raw_go", 7, 1, 0, 0, 8, 1, 0, 0, 0, 0);
        idle("drain", 3);
`endif

        op("wr_x0",  0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
        op("use_x0", 0, 1, 0, 1, 11, 1, 0, 0, 0, 0);
        idle("drain", 3);

        // Taken branch with a second branch and a RAW source during the squash
        op("add_x7f", 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        cyc("br_accept",  1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("flush1",     1, 1, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, -1, -1);
        cyc("flush2",     1, 1, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, -1, -1);
        op("post_flush", 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("drain", 3);

        // Freeze during a load-use stall
        op("lw_x6e", 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
        repeat (4) cyc("frozen", 1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 1, 1, 1, 0, -1, -1);
        repeat (SLEN) op("rel_stall", 0, 0, 6, 1, 0, 0, 0, 1, -1, -1);
        op("rel_go", 0, 0, 6, 1, 0, 0, 0, 0, 0, FWD ? 2 : 0);
        idle("drain", 3);

        while (ecnt < CNT_MAX) begin
            op("sat_lw", 0, 0, 0, 0, 6, 1, 1, 0, -1, -1);
            repeat (SLEN) op("sat_stall", 6, 1, 0, 0, 0, 0, 0, 1, -1, -1);
            op("sat_go", 6, 1, 0, 0, 0, 0, 0, 0, -1, -1);
        end
        op("hold_lw", 0, 0, 0, 0, 6, 1, 1, 0, -1, -1);
        repeat (SLEN) op("sat_hold", 6, 1, 0, 0, 0, 0, 0, 1, -1, -1);
        op("hold_go", 6, 1, 0, 0, 0, 0, 0, 0, -1, -1);

        // Asynchronous reset in the middle of a flush with the counter saturated
        cyc("br_sat",    1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("mid_flush", 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, -1, -1);
        cyc("async_rst", 0, 1, 6, 1, 6, 1, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        if (stall_o !== 1'b0 || bubble_o !== 1'b0 || flush_o !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst_imm: stall=%b bubble=%b flush=%b not cleared before clock edge",
                     stall_o, bubble_o, flush_o);
        end
        if (stall_cnt_o !== '0) begin
            n_bad++;
            $display("FAIL async_rst_cnt: stall_cnt=%0d not cleared before clock edge", stall_cnt_o);
        end
        if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0) begin
            n_bad++;
            $display("FAIL async_rst_fwd: fwd_a=%0d fwd_b=%0d not cleared", fwd_a_o, fwd_b_o);
        end
        cyc("in_reset",  0, 1, 6, 1, 6, 1, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        idle("post_reset", 2);

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue: %0d expected vectors never checked", q.size());
        end
        if (n_vec < 12) begin
            n_bad++;
            $display("FAIL coverage: only %0d vectors checked", n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad == 0)
            $display("PASS");
        else
            $display("FAIL: %0d errors", n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, stall and flush controller for the in-order pipeline. It tracks in-flight register writers in a shift-register scoreboard spanning NUM_STAGES post-decode stages (default EX/MEM/WB). From this it generates the ID stall, the ID/EX bubble and the post-branch flush, plus a saturating stall counter. Operand forwarding select is a compile-time option.

Parameters:
NUM_STAGES, 3, tracked stages after ID; index 0 = EX, NUM_STAGES-1 = WB
REG_AW, 5, register address width
LOAD_RDY_STAGE, 1, lowest stage index at which a load result is forwardable (1 <= value < NUM_STAGES)
FLUSH_CYCLES, 1, cycles of squash after a taken branch (>= 1)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid_i  in  1  ID holds a real instruction
id_rs1_i  in  REG_AW  ID source 1
id_rs2_i  in  REG_AW  ID source 2
id_use_rs1_i  in  1  instruction reads rs1
id_use_rs2_i  in  1  instruction reads rs2
id_rd_i  in  REG_AW  ID destination
id_rf_w_en_i  in  1  ID instruction writes rd
id_is_load_i  in  1  ID instruction is a load
br_taken_i  in  1  taken branch/jump resolved in ID
ext_stall_i  in  1  whole-pipeline freeze (e.g. memory not ready)
stall_o  out  1  hold PC and IF/ID
bubble_o  out  1  load NOP into ID/EX
flush_o  out  1  squash instruction currently in IF/ID
fwd_a_o  out  $clog2(NUM_STAGES+1)  rs1 source: 0 = regfile, k = stage k-1 (FWD_EN only)
fwd_b_o  out  $clog2(NUM_STAGES+1)  rs2 source, same encoding (FWD_EN only)
stall_cnt_o  out  CNT_W  cycles spent in hazard stall

Behaviour:
- Scoreboard entry per stage: {valid, rd, is_load}. Entries with rd = 0 are stored with valid = 0.
- Match on a source: id_use_rsX_i, rsX != 0, and entry valid with entry.rd == rsX. The youngest (lowest index) match governs.
- Hazard, without FWD_EN: any match in any stage.
- Hazard, with FWD_EN: the youngest match is a load at index < LOAD_RDY_STAGE.
- Forwarding, with FWD_EN and no hazard: fwd_x_o = youngest match index + 1; 0 if no match.
- kill = flush_o. hz = id_valid_i & !kill & hazard.
- stall_o = hz and bubble_o = hz | kill. Both are combinational from the current scoreboard and ID inputs.
- Scoreboard update on posedge clk when ext_stall_i = 0:
  - entry[k] <= entry[k-1] for k >= 1.
  - entry[0] <= {id_valid_i & !bubble_o & id_rf_w_en_i & rd != 0, id_rd_i, id_is_load_i}.
- ext_stall_i = 1: scoreboard, flush counter and stall counter all hold. stall_o/bubble_o still reflect the hazard.
- Flush:
  - br_taken_i is accepted only when id_valid_i & !hz & !kill & !ext_stall_i.
  - On accept, the flush counter loads FLUSH_CYCLES. flush_o = (counter != 0).
  - The counter decrements each non-frozen cycle.
  - br_taken_i during flush or stall is ignored; decode re-presents it.
- Priority: kill over hazard. During flush, stall_o = 0, the ID slot becomes a bubble and the fetch redirect proceeds.
- stall_cnt_o increments when stall_o & !ext_stall_i and saturates at all-ones (no wrap).
- Async reset (reset = 0):
  - All entries invalid, flush counter 0, stall_cnt_o 0.
  - Hence stall_o = bubble_o = flush_o = 0 and fwd_* = 0.
  - Reset mid-stall or mid-flush discards both immediately.

Optional Feature:
PIPE_HAZARD_FWD_EN:
- Defined: forwarding select logic is present, and only load-use stalls occur.
- Undefined: fwd_a_o/fwd_b_o are tied 0, and any RAW match stalls until the producer leaves the last tracked stage.

Test Plan:
1. FWD_EN, defaults: ADD x5 followed by SUB using rs1 = x5 -> stall_o stays 0; fwd_a_o = 1 in the SUB's ID cycle, and fwd_a_o = 2 if one independent instruction sits between them.
2. FWD_EN: LW x6 followed directly by a user of rs2 = x6 -> exactly 1 cycle with stall_o = bubble_o = 1, then fwd_b_o = 2; stall_cnt_o = 1.
3. No FWD_EN: ADD x7 followed by a user of x7 -> 3 stall cycles, then fwd = 0 and proceed. A use of x0 after a write to x0 -> no stall.
4. br_taken_i with FLUSH_CYCLES = 2 -> flush_o high for exactly 2 cycles with bubble_o = 1. A second br_taken_i during the flush -> ignored.
5. ext_stall_i high for 4 cycles during a load-use stall -> scoreboard frozen and stall_cnt_o unchanged. After release -> remaining stall of 1 cycle.
6. Assert reset low mid-flush with stall_cnt_o = 0xFFFF (saturated) -> all outputs 0 immediately. Before the reset, a further stall leaves the count at 0xFFFF.
